// File: rtl/mdu_ctrl_pkg.sv
// mdu_ctrl_pkg: opcode/state encodings and opcode decode helpers for the mul/div sequencer
package mdu_ctrl_pkg;
  typedef enum logic [1:0] {MDU_MULT = 2'b00, MDU_MULTU = 2'b01, MDU_DIV = 2'b10, MDU_DIVU = 2'b11} mdu_op_e;
  typedef enum logic [1:0] {MDU_IDLE = 2'b00, MDU_CALC = 2'b01, MDU_DONE = 2'b10} mdu_state_e;
  function automatic logic is_div(input mdu_op_e op);
    return op == MDU_DIV || op == MDU_DIVU;
  endfunction
  function automatic logic is_signed(input mdu_op_e op);
    return op == MDU_MULT || op == MDU_DIV;
  endfunction
endpackage

// File: rtl/mdu_ctrl_if.sv
// mdu_ctrl_if: EX-stage request/result bundle between the pipeline and the mul/div sequencer
interface mdu_ctrl_if import mdu_ctrl_pkg::*; #(parameter int WIDTH = 32) ();
  logic start_i;
  mdu_op_e op_i;
  logic [WIDTH-1:0] src_a_i;
  logic [WIDTH-1:0] src_b_i;
  logic stallreq_for_ex;
  logic result_valid_o;
  logic [WIDTH-1:0] hi_o;
  logic [WIDTH-1:0] lo_o;
  modport master(output start_i, op_i, src_a_i, src_b_i, input stallreq_for_ex, result_valid_o, hi_o, lo_o);
  modport slave(input start_i, op_i, src_a_i, src_b_i, output stallreq_for_ex, result_valid_o, hi_o, lo_o);
endinterface

// File: rtl/mdu_ctrl_iter.sv
// mdu_ctrl_iter: unsigned shift-add multiply / restoring divide datapath, one iteration per step
module mdu_ctrl_iter import mdu_ctrl_pkg::*; #(parameter int WIDTH = 32) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_load,
  input  logic               i_step,
  input  mdu_op_e            i_op,
  input  logic [WIDTH-1:0]   i_mag_a,
  input  logic [WIDTH-1:0]   i_mag_b,
  output logic [2*WIDTH-1:0] o_acc_nxt
);
  logic r_div;
  logic [WIDTH-1:0] r_opnd;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH:0] w_sum;
  logic [WIDTH-1:0] w_diff;
  logic w_ge;
  // shifted remainder can reach WIDTH+1 bits, so the compare includes the bit shifted out
  always_comb begin
    w_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : {(WIDTH+1){1'b0}});
    w_ge = r_acc[2*WIDTH-1:WIDTH-1] >= {1'b0, r_opnd};
    w_diff = r_acc[2*WIDTH-2:WIDTH-1] - r_opnd;
    o_acc_nxt = !r_div ? {w_sum, r_acc[WIDTH-1:1]} :
                w_ge ? {w_diff, r_acc[WIDTH-2:0], 1'b1} : {r_acc[2*WIDTH-2:0], 1'b0};
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div <= 1'b0;
      r_opnd <= '0;
      r_acc <= '0;
    end else if (i_load) begin
      r_div <= is_div(i_op);
      r_opnd <= is_div(i_op) ? i_mag_b : i_mag_a;
      r_acc <= {{WIDTH{1'b0}}, is_div(i_op) ? i_mag_a : i_mag_b};
    end else if (i_step) begin
      r_acc <= o_acc_nxt;
    end
  end
endmodule

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: iterative MULT/MULTU/DIV/DIVU sequencer that stalls EX and returns HI/LO
module mdu_ctrl import mdu_ctrl_pkg::*; #(parameter int WIDTH = 32) (
  input logic       clk,
  input logic       rst,
  mdu_ctrl_if.slave bus
);
  mdu_state_e r_state, w_state_nxt;
  mdu_op_e r_op;
  logic [5:0] r_cnt;
  logic r_sa, r_sb, r_dz;
  logic [WIDTH-1:0] r_raw_a, r_hi, r_lo;
  logic w_load, w_step, w_last, w_sa, w_sb, w_neg;
  logic [WIDTH-1:0] w_mag_a, w_mag_b, w_hi, w_lo, w_q, w_r;
  logic [2*WIDTH-1:0] w_acc_nxt, w_prod;
  mdu_ctrl_iter #(.WIDTH(WIDTH)) u_iter (
    .clk(clk), .rst(rst), .i_load(w_load), .i_step(w_step), .i_op(bus.op_i),
    .i_mag_a(w_mag_a), .i_mag_b(w_mag_b), .o_acc_nxt(w_acc_nxt)
  );
  always_comb begin
    w_load = r_state == MDU_IDLE && bus.start_i;
    w_step = r_state == MDU_CALC;
    w_last = w_step && r_cnt == 6'(WIDTH-1);
    w_state_nxt = r_state == MDU_IDLE ? (bus.start_i ? MDU_CALC : MDU_IDLE) :
                  r_state == MDU_CALC ? (w_last ? MDU_DONE : MDU_CALC) : MDU_IDLE;
    w_sa = is_signed(bus.op_i) & bus.src_a_i[WIDTH-1];
    w_sb = is_signed(bus.op_i) & bus.src_b_i[WIDTH-1];
    w_mag_a = w_sa ? -bus.src_a_i : bus.src_a_i;
    w_mag_b = w_sb ? -bus.src_b_i : bus.src_b_i;
    w_neg = r_sa ^ r_sb;
    w_prod = w_neg ? -w_acc_nxt : w_acc_nxt;
    w_q = w_acc_nxt[WIDTH-1:0];
    w_r = w_acc_nxt[2*WIDTH-1:WIDTH];
    w_hi = !is_div(r_op) ? w_prod[2*WIDTH-1:WIDTH] : r_dz ? r_raw_a : r_sa ? -w_r : w_r;
    w_lo = !is_div(r_op) ? w_prod[WIDTH-1:0] : r_dz ? '1 : w_neg ? -w_q : w_q;
    // gated by rst so the stall drops in the very cycle reset is asserted
    bus.stallreq_for_ex = !rst && (w_load || w_step);
    bus.result_valid_o = r_state == MDU_DONE;
    bus.hi_o = r_hi;
    bus.lo_o = r_lo;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= MDU_IDLE;
    else r_state <= w_state_nxt;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op <= MDU_MULT;
      r_cnt <= '0;
      r_sa <= 1'b0;
      r_sb <= 1'b0;
      r_dz <= 1'b0;
      r_raw_a <= '0;
      r_hi <= '0;
      r_lo <= '0;
    end else begin
      if (w_load) begin
        r_op <= bus.op_i;
        r_cnt <= '0;
        r_sa <= w_sa;
        r_sb <= w_sb;
        r_dz <= is_div(bus.op_i) && bus.src_b_i == '0;
        r_raw_a <= bus.src_a_i;
      end
      if (w_step) r_cnt <= r_cnt + 6'd1;
      if (w_last) begin
        r_hi <= w_hi;
        r_lo <= w_lo;
      end
    end
  end
endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: randomized and directed checks of mdu_ctrl against an arithmetic reference model
module tb_mdu_ctrl;
  import mdu_ctrl_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_tests = 0;
  int n_fail = 0;
  mdu_ctrl_if #(.WIDTH(32)) bus ();
  mdu_ctrl #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  logic [1:0]  d_op [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd2};
  logic [31:0] d_a  [6] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'd7, 32'd7, 32'h80000000};
  logic [31:0] d_b  [6] = '{32'd2, 32'd2, 32'd2, 32'd2, 32'd0, 32'd0};
  logic [31:0] d_hi [6] = '{32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF, 32'd1, 32'd7, 32'h80000000};
  logic [31:0] d_lo [6] = '{32'hFFFFFFFE, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFF};

  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    if (op == 2'd0) return 64'(sa * sb);
    if (op == 2'd1) return {32'b0, a} * {32'b0, b};
    if (b == 32'd0) return {a, 32'hFFFFFFFF};
    if (op == 2'd2) return {32'(sa % sb), 32'(sa / sb)};
    return {a % b, a / b};
  endfunction

  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output int stalls, output logic [31:0] hi, output logic [31:0] lo);
    @(negedge clk);
    bus.start_i = 1'b1;
    bus.op_i = mdu_op_e'(op);
    bus.src_a_i = a;
    bus.src_b_i = b;
    #1;
    stalls = bus.stallreq_for_ex ? 1 : 0;
    lat = 0;
    hi = 'x;
    lo = 'x;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (bus.stallreq_for_ex) stalls++;
      if (bus.result_valid_o) begin
        lat = c;
        hi = bus.hi_o;
        lo = bus.lo_o;
        break;
      end
      bus.op_i = mdu_op_e'(2'($urandom_range(0, 3)));
      bus.src_a_i = $urandom;
      bus.src_b_i = $urandom;
    end
  endtask

  task automatic test_reset();
    bus.start_i = 1'b0;
    bus.op_i = MDU_MULT;
    bus.src_a_i = '0;
    bus.src_b_i = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    n_tests++;
    if (bus.stallreq_for_ex !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %b want 0", bus.stallreq_for_ex); end
    n_tests++;
    if (bus.result_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", bus.result_valid_o); end
    n_tests++;
    if (bus.hi_o !== 32'd0) begin n_fail++; $display("FAIL reset_hi got %h want 0", bus.hi_o); end
    n_tests++;
    if (bus.lo_o !== 32'd0) begin n_fail++; $display("FAIL reset_lo got %h want 0", bus.lo_o); end
  endtask

  task automatic test_directed();
    int lat, stalls;
    logic [31:0] hi, lo;
    for (int i = 0; i < 6; i++) begin
      do_op(d_op[i], d_a[i], d_b[i], lat, stalls, hi, lo);
      n_tests++;
      if (lat !== 33) begin n_fail++; $display("FAIL dir%0d_latency got %0d want 33", i, lat); end
      n_tests++;
      if (stalls !== 33) begin n_fail++; $display("FAIL dir%0d_stall_cycles got %0d want 33", i, stalls); end
      n_tests++;
      if (hi !== d_hi[i]) begin n_fail++; $display("FAIL dir%0d_hi got %h want %h", i, hi, d_hi[i]); end
      n_tests++;
      if (lo !== d_lo[i]) begin n_fail++; $display("FAIL dir%0d_lo got %h want %h", i, lo, d_lo[i]); end
      @(negedge clk);
      bus.start_i = 1'b0;
      #1;
      n_tests++;
      if (bus.result_valid_o !== 1'b0) begin n_fail++; $display("FAIL dir%0d_pulse got %b want 0", i, bus.result_valid_o); end
      n_tests++;
      if (bus.hi_o !== d_hi[i]) begin n_fail++; $display("FAIL dir%0d_hi_hold got %h want %h", i, bus.hi_o, d_hi[i]); end
    end
  endtask

  task automatic test_random();
    int lat, stalls;
    logic [31:0] hi, lo, a, b;
    logic [1:0] op;
    logic [63:0] exp;
    for (int i = 0; i < 60; i++) begin
      op = 2'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 9))
        0: b = 32'd0;
        1: a = 32'h80000000;
        2: b = 32'hFFFFFFFF;
        3: a = 32'd0;
        4: b = 32'd1;
        5: b = 32'($urandom_range(1, 15));
        default: ;
      endcase
      exp = model(op, a, b);
      do_op(op, a, b, lat, stalls, hi, lo);
      n_tests++;
      if (lat !== 33) begin n_fail++; $display("FAIL rnd%0d_latency got %0d want 33", i, lat); end
      n_tests++;
      if (hi !== exp[63:32]) begin n_fail++; $display("FAIL rnd%0d_hi op=%0d a=%h b=%h got %h want %h", i, op, a, b, hi, exp[63:32]); end
      n_tests++;
      if (lo !== exp[31:0]) begin n_fail++; $display("FAIL rnd%0d_lo op=%0d a=%h b=%h got %h want %h", i, op, a, b, lo, exp[31:0]); end
      @(negedge clk);
      bus.start_i = 1'b0;
    end
  endtask

  task automatic test_back_to_back();
    int lat1, lat2, lat3, st2;
    logic [31:0] hi, lo, a1, b1, a2, b2, a3, b3;
    logic [63:0] exp;
    a1 = $urandom; b1 = $urandom; a2 = $urandom; b2 = $urandom; a3 = $urandom; b3 = 32'($urandom_range(1, 1000));
    do_op(2'd0, a1, b1, lat1, st2, hi, lo);
    exp = model(2'd0, a1, b1);
    n_tests++;
    if ({hi, lo} !== exp) begin n_fail++; $display("FAIL b2b_first got %h want %h", {hi, lo}, exp); end
    do_op(2'd0, a2, b2, lat2, st2, hi, lo);
    exp = model(2'd0, a2, b2);
    n_tests++;
    if (lat1 + 1 + lat2 !== 67) begin n_fail++; $display("FAIL b2b_second_cycle got %0d want 67", lat1 + 1 + lat2); end
    n_tests++;
    if (st2 !== 33) begin n_fail++; $display("FAIL b2b_second_stalls got %0d want 33", st2); end
    n_tests++;
    if ({hi, lo} !== exp) begin n_fail++; $display("FAIL b2b_second got %h want %h", {hi, lo}, exp); end
    do_op(2'd2, a3, b3, lat3, st2, hi, lo);
    exp = model(2'd2, a3, b3);
    n_tests++;
    if (lat3 !== 33) begin n_fail++; $display("FAIL b2b_third_latency got %0d want 33", lat3); end
    n_tests++;
    if ({hi, lo} !== exp) begin n_fail++; $display("FAIL b2b_third got %h want %h", {hi, lo}, exp); end
    @(negedge clk);
    bus.start_i = 1'b0;
  endtask

  task automatic test_reset_mid();
    int lat, stalls;
    logic [31:0] hi, lo, a, b;
    logic [63:0] exp;
    do_op(2'd1, 32'hFFFFFFFF, 32'd2, lat, stalls, hi, lo);
    @(negedge clk);
    bus.start_i = 1'b0;
    @(negedge clk);
    bus.start_i = 1'b1;
    bus.op_i = MDU_DIV;
    bus.src_a_i = 32'h12345678;
    bus.src_b_i = 32'd3;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    n_tests++;
    if (bus.stallreq_for_ex !== 1'b0) begin n_fail++; $display("FAIL midrst_stall got %b want 0", bus.stallreq_for_ex); end
    n_tests++;
    if (bus.result_valid_o !== 1'b0) begin n_fail++; $display("FAIL midrst_valid got %b want 0", bus.result_valid_o); end
    n_tests++;
    if (bus.hi_o !== 32'd0) begin n_fail++; $display("FAIL midrst_hi got %h want 0", bus.hi_o); end
    n_tests++;
    if (bus.lo_o !== 32'd0) begin n_fail++; $display("FAIL midrst_lo got %h want 0", bus.lo_o); end
    @(negedge clk);
    rst = 1'b0;
    bus.start_i = 1'b0;
    a = $urandom;
    b = 32'($urandom_range(1, 50000));
    exp = model(2'd3, a, b);
    do_op(2'd3, a, b, lat, stalls, hi, lo);
    n_tests++;
    if (lat !== 33) begin n_fail++; $display("FAIL postrst_latency got %0d want 33", lat); end
    n_tests++;
    if ({hi, lo} !== exp) begin n_fail++; $display("FAIL postrst_result got %h want %h", {hi, lo}, exp); end
    @(negedge clk);
    bus.start_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mdu_ctrl.md
# mdu_ctrl

Iterative multiply/divide sequencer for the EX stage. It accepts MULT/MULTU/DIV/DIVU requests, runs a 32-step shift-add or restoring-divide engine, and returns 64-bit HI/LO results. While busy it raises `stallreq_for_ex` so the pipeline stall controller freezes PC/IF/ID/EX. MEM/WB drain normally.

## Interface
Parameters:
- `WIDTH`, 32: operand width. The iteration count equals `WIDTH`.

Ports:
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start_i` in 1: EX holds a mul/div instruction. Stays high for the whole stall because EX is frozen.
- `op_i` in 2: `MDU_MULT`=00, `MDU_MULTU`=01, `MDU_DIV`=10, `MDU_DIVU`=11.
- `src_a_i` in WIDTH: multiplicand or dividend (rs).
- `src_b_i` in WIDTH: multiplier or divisor (rt).
- `stallreq_for_ex` out 1: stall request to the pipeline stall controller.
- `result_valid_o` out 1: one-cycle pulse; `hi_o`/`lo_o` are valid for HI/LO write this cycle.
- `hi_o` out WIDTH: product[63:32] or remainder.
- `lo_o` out WIDTH: product[31:0] or quotient.

## Operation
- FSM states: IDLE, CALC, DONE. Reset state is IDLE.
- IDLE → CALC when `start_i`=1. Latch on that edge:
  - `op_i`.
  - Operand signs: taken only for signed ops; 0 for unsigned.
  - Operand magnitudes: two's-complement absolute value for signed ops; raw value for unsigned.
  - Clear the 6-bit step counter.
- CALC: one iteration per cycle. Leave for DONE after iteration `WIDTH`-1, i.e. 32 cycles in CALC.
  - Multiply: 64-bit accumulator. If the multiplier LSB is 1, add the multiplicand into the upper half. Then shift right by 1.
  - Divide (restoring): shift {rem, quo} left by 1. Trial-subtract the divisor from rem. If the result is non-negative, keep it and set quo[0]=1.
- DONE → IDLE unconditionally. `start_i` is ignored in DONE because the same instruction is still in EX that cycle.
- Sign fix-up, applied on the CALC→DONE edge:
  - Product: negate the 64-bit product if sign_a^sign_b.
  - Quotient: negate if sign_a^sign_b.
  - Remainder: negate if sign_a.
- Divide by zero (`src_b_i`==0, any div op): `hi_o`=`src_a_i` as latched (raw), `lo_o`=32'hFFFFFFFF. No sign fix-up. Full latency is still taken.
- Outputs:
  - `stallreq_for_ex` = (IDLE & `start_i`) | CALC. This is combinational so the first cycle stalls; it is 0 in DONE.
  - `result_valid_o` = (state==DONE).
  - `hi_o`/`lo_o`: registered, loaded on the CALC→DONE edge. They hold their value until the next load.
- Reset values: state IDLE, counter 0, `hi_o`=0, `lo_o`=0, `result_valid_o`=0. With `start_i`=0, `stallreq_for_ex`=0.
- Reset mid-operation: the FSM returns to IDLE immediately and the partial result is discarded. `hi_o`/`lo_o` read 0.

## Timing
- Cycle 0: IDLE with `start_i`=1; `stallreq_for_ex`=1.
- Cycles 1–32: CALC; `stallreq_for_ex`=1.
- Cycle 33: DONE; `result_valid_o`=1 and `stallreq_for_ex`=0, so EX advances at the end of the cycle.
- Total stall: 33 cycles. Issue to result: 33 cycles.
- Back-to-back mul/div: the next instruction reaches EX in cycle 34 (IDLE) and is accepted there. There is no dead cycle beyond DONE.
- `src_a_i`/`src_b_i`/`op_i` are sampled only in the IDLE→CALC cycle. Changes afterwards have no effect.
- The stall controller gives `stallreq_for_ex` the highest priority, so EX is never frozen by another source while this block is busy.

## Structure
- `lib/defines.vh` gets:
  - `MduOpBus` (2).
  - Codes `MDU_MULT`, `MDU_MULTU`, `MDU_DIV`, `MDU_DIVU`.
  - `MduStateBus` (2) with `MDU_IDLE`=00, `MDU_CALC`=01, `MDU_DONE`=10.
- Sub-module `mdu_iter` holds the datapath:
  - Accumulator/remainder registers and one-step add/trial-subtract logic.
  - Controls: `load`, `step`, `op`.
- `mdu_ctrl` keeps the FSM, the counter, sign fix-up, the divide-by-zero override and the output registers.

## Test plan
- MULT 0xFFFFFFFF × 0x00000002 → after 33 stall cycles, `hi_o`=FFFFFFFF, `lo_o`=FFFFFFFE, `result_valid_o` high exactly one cycle.
- MULTU 0xFFFFFFFF × 0x00000002 → `hi_o`=00000001, `lo_o`=FFFFFFFE.
- DIV 0xFFFFFFF9 (−7) ÷ 0x00000002 → `lo_o`=FFFFFFFD (−3), `hi_o`=FFFFFFFF (−1). DIVU 7 ÷ 2 → `lo_o`=3, `hi_o`=1.
- DIVU 7 ÷ 0 and DIV 0x80000000 ÷ 0 → `hi_o`=src_a (00000007 / 80000000), `lo_o`=FFFFFFFF, latency still 33.
- `start_i` held high through DONE, then the next MULT in cycle 34 → no retrigger in DONE; the second op is accepted in cycle 34 and its result appears in cycle 67.
- Assert `rst` during CALC cycle 10 → `stallreq_for_ex`, `result_valid_o`, `hi_o`, `lo_o` all 0 in the same cycle. A new op after reset deasserts completes with correct values.
